// File: rtl/fcs32_16_tx.sv
// Transmit-side FCS inserter for the 16-bit framed datapath: forwards payload words
// and appends the two-word Ethernet CRC-32 FCS after the last payload word.
module fcs32_16_tx #(
    parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF
) (
    input  logic        pclk_i,
    input  logic        rst_n_i,
    input  logic [15:0] data_i,
    input  logic        sof_i,
    input  logic        eof_i,
    input  logic        vld_i,
    output logic        rdy_o,
    output logic [15:0] data_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic        vld_o,
    input  logic        rdy_i,
    output logic        seq_err_o
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_FCS_HI,
        S_FCS_LO
    } state_t;

    // CRC-32 (poly 04C11DB7) advanced by one 16-bit word, word MSB first.
    function automatic logic [CW-1:0] fcs32_16(input logic [DW-1:0] d, input logic [CW-1:0] c);
        logic [CW-1:0] r;
        r = c;
        for (int i = DW - 1; i >= 0; i--) begin
            if (r[CW-1] ^ d[i]) r = {r[CW-2:0], 1'b0} ^ 32'h04C1_1DB7;
            else                r = {r[CW-2:0], 1'b0};
        end
        return r;
    endfunction

    // Final FCS value: bit-reversed and complemented CRC register.
    function automatic logic [CW-1:0] fcs32_brev(input logic [CW-1:0] c);
        logic [CW-1:0] r;
        for (int i = 0; i < int'(CW); i++) r[i] = ~c[CW-1-i];
        return r;
    endfunction

    state_t          state, state_nxt;
    logic [CW-1:0]   crc, crc_nxt;
    logic [DW-1:0]   data_nxt;
    logic            sof_nxt, eof_nxt, vld_nxt, seq_err_nxt;
    logic            slot_free, accept;
    logic [CW-1:0]   fcs;

    assign slot_free = !vld_o || rdy_i;
    assign rdy_o     = ((state == S_IDLE) || (state == S_DATA)) && slot_free;
    assign accept    = vld_i && rdy_o;
    assign fcs       = fcs32_brev(crc);

    // State, CRC and output register stage.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= S_IDLE;
            crc       <= CRC_INIT;
            data_o    <= '0;
            sof_o     <= 1'b0;
            eof_o     <= 1'b0;
            vld_o     <= 1'b0;
            seq_err_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            crc       <= crc_nxt;
            data_o    <= data_nxt;
            sof_o     <= sof_nxt;
            eof_o     <= eof_nxt;
            vld_o     <= vld_nxt;
            seq_err_o <= seq_err_nxt;
        end
    end

    // Next state; the output slot holds its beat until downstream takes it.
    always_comb begin
        state_nxt   = state;
        crc_nxt     = crc;
        data_nxt    = data_o;
        sof_nxt     = sof_o;
        eof_nxt     = eof_o;
        vld_nxt     = vld_o && !rdy_i;
        seq_err_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (sof_i) begin
                        crc_nxt   = fcs32_16(data_i, CRC_INIT);
                        data_nxt  = data_i;
                        sof_nxt   = 1'b1;
                        eof_nxt   = 1'b0;
                        vld_nxt   = 1'b1;
                        state_nxt = eof_i ? S_FCS_HI : S_DATA;
                    end else begin
                        seq_err_nxt = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    // A sof here abandons the current frame and restarts the CRC.
                    crc_nxt     = fcs32_16(data_i, sof_i ? CRC_INIT : crc);
                    data_nxt    = data_i;
                    sof_nxt     = sof_i;
                    eof_nxt     = 1'b0;
                    vld_nxt     = 1'b1;
                    seq_err_nxt = sof_i;
                    if (eof_i) state_nxt = S_FCS_HI;
                end
            end
            S_FCS_HI: begin
                if (slot_free) begin
                    data_nxt  = fcs[31:16];
                    sof_nxt   = 1'b0;
                    eof_nxt   = 1'b0;
                    vld_nxt   = 1'b1;
                    state_nxt = S_FCS_LO;
                end
            end
            S_FCS_LO: begin
                if (slot_free) begin
                    data_nxt  = fcs[15:0];
                    sof_nxt   = 1'b0;
                    eof_nxt   = 1'b1;
                    vld_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fcs32_16_tx.sv
// Self-checking bench for fcs32_16_tx: directed frames plus randomized frames and
// backpressure, checked against a frame-level polynomial-division CRC model.
module tb_fcs32_16_tx;

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [32:0] GEN      = 33'h1_04C1_1DB7;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
        logic        e;
    } beat_t;

    logic        pclk_i = 1'b0;
    logic        rst_n_i;
    logic [15:0] data_i;
    logic        sof_i, eof_i, vld_i;
    logic        rdy_o;
    logic [15:0] data_o;
    logic        sof_o, eof_o, vld_o;
    logic        rdy_i;
    logic        seq_err_o;

    fcs32_16_tx #(.CRC_INIT(CRC_INIT)) dut (
        .pclk_i   (pclk_i),
        .rst_n_i  (rst_n_i),
        .data_i   (data_i),
        .sof_i    (sof_i),
        .eof_i    (eof_i),
        .vld_i    (vld_i),
        .rdy_o    (rdy_o),
        .data_o   (data_o),
        .sof_o    (sof_o),
        .eof_o    (eof_o),
        .vld_o    (vld_o),
        .rdy_i    (rdy_i),
        .seq_err_o(seq_err_o)
    );

    always #5 pclk_i = ~pclk_i;

    int    n_vec = 0;
    int    n_err = 0;
    int    rdy_mode = 0;
    bit    gap_en = 0;
    int    last_wait;
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    obs_base = 0;
    int    seq_cnt = 0;
    int    stall_viol = 0;
    logic  hold_v = 1'b0;
    beat_t hold_b;

    // Reference: remainder of (INIT*x^len + M*x^32) mod G by long division, then ~bitreverse.
    function automatic logic [31:0] ref_fcs(input logic [15:0] w[$]);
        bit          a[$];
        int          len;
        logic [31:0] r;
        len = w.size() * 16;
        foreach (w[k]) for (int b = 15; b >= 0; b--) a.push_back(w[k][b]);
        repeat (32) a.push_back(1'b0);
        for (int i = 0; i < 32; i++) a[i] ^= CRC_INIT[31-i];
        for (int i = 0; i < len; i++)
            if (a[i]) for (int j = 0; j <= 32; j++) a[i+j] ^= GEN[32-j];
        for (int j = 0; j < 32; j++) r[31-j] = a[len+j];
        return ~{<<{r}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_frame(input logic [15:0] w[$], input bit with_fcs);
        logic [31:0] f;
        foreach (w[k]) exp_q.push_back(beat_t'{w[k], k == 0, 1'b0});
        if (with_fcs) begin
            f = ref_fcs(w);
            exp_q.push_back(beat_t'{f[31:16], 1'b0, 1'b0});
            exp_q.push_back(beat_t'{f[15:0], 1'b0, 1'b1});
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic s, input logic e);
        bit acc;
        int w;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            vld_i = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge pclk_i); #1; end
        end
        data_i = d; sof_i = s; eof_i = e; vld_i = 1'b1;
        acc = 1'b0; w = 0;
        while (!acc && w < 200) begin
            @(negedge pclk_i);
            acc = rdy_o;
            @(posedge pclk_i); #1;
            if (!acc) w++;
        end
        last_wait = w;
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_frame(input logic [15:0] w[$], output int first_wait);
        first_wait = 0;
        foreach (w[k]) begin
            send_word(w[k], k == 0, k == w.size() - 1);
            if (k == 0) first_wait = last_wait;
        end
    endtask

    task automatic check_out(input string tag);
        int c;
        c = 0;
        vld_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
        while (obs_q.size() - obs_base < exp_q.size() && c < 3000) begin
            @(posedge pclk_i); #1; c++;
        end
        repeat (6) begin @(posedge pclk_i); #1; end
        chk({tag, ".len"}, 32'(obs_q.size() - obs_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (obs_base + i < obs_q.size())
                chk($sformatf("%s[%0d]", tag, i), 32'(obs_q[obs_base+i]), 32'(exp_q[i]));
        obs_base = obs_q.size();
        exp_q.delete();
    endtask

    // Output monitor: collects handed-off beats, seq_err pulses and stall-hold violations.
    always @(negedge pclk_i) begin
        if (!rst_n_i) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v && (!vld_o || beat_t'{data_o, sof_o, eof_o} !== hold_b))
                stall_viol <= stall_viol + 1;
            hold_v <= vld_o && !rdy_i;
            hold_b <= beat_t'{data_o, sof_o, eof_o};
            if (vld_o && rdy_i) obs_q.push_back(beat_t'{data_o, sof_o, eof_o});
            if (seq_err_o) seq_cnt <= seq_cnt + 1;
        end
    end

    // Downstream ready: always, 1,0,0,1 pattern, or random.
    initial begin
        int ph;
        ph = 0;
        rdy_i = 1'b1;
        forever begin
            @(posedge pclk_i); #1;
            case (rdy_mode)
                0:       rdy_i = 1'b1;
                1:       begin rdy_i = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
                default: rdy_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] f[$];
        logic [15:0] g[$];
        int          fw;
        int          seq_base;
        int          len;

        rst_n_i = 1'b0; data_i = '0; sof_i = 1'b0; eof_i = 1'b0; vld_i = 1'b0;
        repeat (3) @(posedge pclk_i);
        #1 rst_n_i = 1'b1;
        @(negedge pclk_i);
        chk("rst.vld_o", 32'(vld_o), 32'd0);
        chk("rst.sof_o", 32'(sof_o), 32'd0);
        chk("rst.eof_o", 32'(eof_o), 32'd0);
        chk("rst.data_o", 32'(data_o), 32'd0);
        chk("rst.seq_err_o", 32'(seq_err_o), 32'd0);
        chk("rst.rdy_o", 32'(rdy_o), 32'd1);
        @(posedge pclk_i); #1;

        // T1: single-word frame
        f = {16'h1234};
        expect_frame(f, 1'b1);
        send_frame(f, fw);
        check_out("T1");

        // T2: 32-word frame, no backpressure
        f.delete();
        for (int i = 1; i <= 32; i++) f.push_back(16'(i));
        expect_frame(f, 1'b1);
        send_frame(f, fw);
        check_out("T2");

        // T3: same frame with ready pattern 1,0,0,1
        rdy_mode = 1;
        expect_frame(f, 1'b1);
        send_frame(f, fw);
        check_out("T3");
        chk("T3.stall_hold", 32'(stall_viol), 32'd0);
        rdy_mode = 0;

        // T4: back-to-back frames with vld_i held high
        f.delete(); g.delete();
        for (int i = 0; i < 4; i++) f.push_back(16'($urandom));
        for (int i = 0; i < 6; i++) g.push_back(16'($urandom));
        expect_frame(f, 1'b1);
        expect_frame(g, 1'b1);
        send_frame(f, fw);
        send_frame(g, fw);
        chk("T4.rdy_gap", 32'(fw), 32'd2);
        check_out("T4");

        // T5: stray word in IDLE, then sof in the middle of a frame
        seq_base = seq_cnt;
        f = {16'hA001, 16'hA002, 16'hA003};
        g = {16'hB001, 16'hB002, 16'hB003, 16'hB004};
        send_word(16'hDEAD, 1'b0, 1'b0);
        expect_frame(f, 1'b0);
        foreach (f[k]) send_word(f[k], k == 0, 1'b0);
        expect_frame(g, 1'b1);
        send_frame(g, fw);
        check_out("T5");
        chk("T5.seq_err", 32'(seq_cnt - seq_base), 32'd2);

        // T6: reset pulse while in FCS_HI
        f = {16'hC001, 16'hC002, 16'hC003};
        exp_q.push_back(beat_t'{f[0], 1'b1, 1'b0});
        exp_q.push_back(beat_t'{f[1], 1'b0, 1'b0});
        send_frame(f, fw);
        rst_n_i = 1'b0;
        #1;
        chk("T6.vld_async", 32'(vld_o), 32'd0);
        chk("T6.rdy_in_rst", 32'(rdy_o), 32'd1);
        vld_i = 1'b0;
        repeat (2) @(posedge pclk_i);
        #1 rst_n_i = 1'b1;
        check_out("T6.drop");
        f.delete();
        for (int i = 0; i < 5; i++) f.push_back(16'($urandom));
        expect_frame(f, 1'b1);
        send_frame(f, fw);
        check_out("T6.next");

        // Randomized frames with random backpressure and input gaps
        seq_base = seq_cnt;
        rdy_mode = 2;
        gap_en = 1'b1;
        for (int n = 0; n < 10; n++) begin
            f.delete();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) f.push_back(16'($urandom));
            expect_frame(f, 1'b1);
            send_frame(f, fw);
            check_out($sformatf("R%0d", n));
        end
        chk("R.seq_err", 32'(seq_cnt - seq_base), 32'd0);
        chk("R.stall_hold", 32'(stall_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
